// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its write-back arbiter.
// Register-file geometry and the write-back request record live here.
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NREG       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_req_t;

    // Round-robin successor of idx in a ring of n slots.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker: the first valid requester at or after ptr,
// searching upward and wrapping from NREQ-1 back to 0, gets a one-hot grant.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: round-robin grant among NREQ requesters, one registered
// stage to the register-file write port. Define WB_BYPASS_EN to add read bypass.
module regfile_wb_arbiter #(
    parameter int NREQ = 4,
    parameter int XLEN = regfile_pkg::XLEN
) (
    input  logic                                        clk,
    input  logic                                        reset_n,
    input  logic                                        stall,
    input  logic [NREQ-1:0]                             req_valid,
    input  logic [NREQ-1:0][regfile_pkg::REG_ADDR_W-1:0] req_rd,
    input  logic [NREQ-1:0][XLEN-1:0]                   req_wd,
    output logic [NREQ-1:0]                             req_ready,
    output logic                                        wb_we,
    output logic [regfile_pkg::REG_ADDR_W-1:0]          wb_rd,
    output logic [XLEN-1:0]                             wb_wd
`ifdef WB_BYPASS_EN
    ,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]          rs1,
    input  logic [regfile_pkg::REG_ADDR_W-1:0]          rs2,
    input  logic [XLEN-1:0]                             rf_rd1,
    input  logic [XLEN-1:0]                             rf_rd2,
    output logic [XLEN-1:0]                             byp_rd1,
    output logic [XLEN-1:0]                             byp_rd2
`endif
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int AW    = regfile_pkg::REG_ADDR_W;

    logic [PTR_W-1:0]         ptr_reg;
    logic [PTR_W-1:0]         ptr_next;
    logic [NREQ-1:0]          grant;
    logic                     hs;
    logic [PTR_W-1:0]         sel_idx;
    logic [AW-1:0]            sel_rd;
    logic [XLEN-1:0]          sel_wd;
    logic [NREQ-1:0][AW-1:0]  rd_masked;
    logic [NREQ-1:0][XLEN-1:0] wd_masked;

    logic                     wb_we_reg;
    logic [AW-1:0]            wb_rd_reg;
    logic [XLEN-1:0]          wb_wd_reg;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    // Grant is only ever raised on a valid requester, so any ready bit is a handshake.
    assign req_ready = stall ? '0 : grant;
    assign hs        = |(req_valid & req_ready);

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign rd_masked[gi] = req_ready[gi] ? req_rd[gi] : '0;
            assign wd_masked[gi] = req_ready[gi] ? req_wd[gi] : '0;
        end
    endgenerate

    always_comb begin
        sel_idx = '0;
        sel_rd  = '0;
        sel_wd  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_rd = sel_rd | rd_masked[i];
            sel_wd = sel_wd | wd_masked[i];
            if (req_ready[i]) begin
                sel_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (hs) begin
            ptr_next = PTR_W'(regfile_pkg::wrap_inc(int'(sel_idx), NREQ));
        end
    end

    // Writes to x0 are accepted upstream but never reach the register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg   <= '0;
            wb_we_reg <= 1'b0;
            wb_rd_reg <= '0;
            wb_wd_reg <= '0;
        end else begin
            ptr_reg   <= ptr_next;
            wb_we_reg <= hs && (sel_rd != '0);
            if (hs) begin
                wb_rd_reg <= sel_rd;
                wb_wd_reg <= sel_wd;
            end
        end
    end

    assign wb_we = wb_we_reg;
    assign wb_rd = wb_rd_reg;
    assign wb_wd = wb_wd_reg;

`ifdef WB_BYPASS_EN
    assign byp_rd1 = (wb_we_reg && (wb_rd_reg == rs1) && (rs1 != '0)) ? wb_wd_reg : rf_rd1;
    assign byp_rd2 = (wb_we_reg && (wb_rd_reg == rs2) && (rs2 != '0)) ? wb_wd_reg : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a behavioural round-robin / register-file model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 4;
    localparam int XLEN = 64;

    logic                       clk;
    logic                       reset_n;
    logic                       stall;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][4:0]       req_rd;
    logic [NREQ-1:0][XLEN-1:0]  req_wd;
    logic [NREQ-1:0]            req_ready;
    logic                       wb_we;
    logic [4:0]                 wb_rd;
    logic [XLEN-1:0]            wb_wd;
`ifdef WB_BYPASS_EN
    logic [4:0]                 rs1, rs2;
    logic [XLEN-1:0]            rf_rd1, rf_rd2, byp_rd1, byp_rd2;
`endif

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .stall     (stall),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_wd     (wb_wd)
`ifdef WB_BYPASS_EN
        ,
        .rs1       (rs1),
        .rs2       (rs2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .byp_rd1   (byp_rd1),
        .byp_rd2   (byp_rd2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file written by the DUT's write port; x0 deliberately unguarded.
    logic [XLEN-1:0] rf_mem [32] = '{default: 64'h0};
    always @(posedge clk) begin
        if (wb_we) rf_mem[wb_rd] <= wb_wd;
    end
`ifdef WB_BYPASS_EN
    assign rf_rd1 = rf_mem[rs1];
    assign rf_rd2 = rf_mem[rs2];
`endif

    // Reference model state
    int              m_ptr;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wd;
    logic [XLEN-1:0] m_rf [32];
    logic [NREQ-1:0] obs_ready;

    logic [4:0]      s_rd [NREQ];
    logic [XLEN-1:0] s_wd [NREQ];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] exp_grant(input logic st, input logic [NREQ-1:0] v);
        if (st) return '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (v[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    task automatic check_wb();
        chk("wb_we", 64'(wb_we), 64'(m_we));
        if (m_we) begin
            chk("wb_rd", 64'(wb_rd), 64'(m_rd));
            chk("wb_wd", wb_wd, m_wd);
        end
    endtask

    task automatic check_rf();
        for (int r = 0; r < 32; r++)
            chk($sformatf("rf_x%0d", r), rf_mem[r], m_rf[r]);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_we  = 1'b0;
        m_rd  = '0;
        m_wd  = '0;
    endtask

    // One clock: check registered outputs, drive inputs, check grant, advance model.
    task automatic do_cycle(input logic st, input logic [NREQ-1:0] v);
        logic [NREQ-1:0] eg;
        int idx;
        @(negedge clk);
        check_wb();
        stall     = st;
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_rd[i] = s_rd[i];
            req_wd[i] = s_wd[i];
        end
        #1;
        eg        = exp_grant(st, v);
        obs_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(eg));
        @(posedge clk);
        if (m_we) m_rf[m_rd] = m_wd;
        if (eg != '0) begin
            idx = 0;
            for (int i = 0; i < NREQ; i++) if (eg[i]) idx = i;
            m_we  = (s_rd[idx] != 5'd0);
            m_rd  = s_rd[idx];
            m_wd  = s_wd[idx];
            m_ptr = (idx + 1) % NREQ;
        end else begin
            m_we = 1'b0;
        end
    endtask

    initial begin
        int gcnt;
        bit got3;

        reset_n   = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_rd    = '0;
        req_wd    = '0;
`ifdef WB_BYPASS_EN
        rs1 = '0;
        rs2 = '0;
`endif
        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_rd[i] = '0;
            s_wd[i] = '0;
        end
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wb_we", 64'(wb_we), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_wd", wb_wd, 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Contention: everyone valid, rd = 1..4
        for (int i = 0; i < NREQ; i++) begin
            s_rd[i] = 5'(i + 1);
            s_wd[i] = {$urandom, $urandom};
        end
        for (int c = 0; c < 4; c++) begin
            do_cycle(1'b0, '1);
            chk($sformatf("contend_grant%0d", c), 64'(obs_ready), 64'(NREQ'(1) << c));
        end
        do_cycle(1'b0, '0);
        do_cycle(1'b0, '0);
        for (int i = 0; i < NREQ; i++)
            chk($sformatf("contend_x%0d", i + 1), rf_mem[i + 1], s_wd[i]);

        // x0 write is accepted but dropped
        s_rd[0] = 5'd0;
        s_wd[0] = 64'hDEAD;
        do_cycle(1'b0, 4'b0001);
        chk("x0_ready", 64'(obs_ready), 64'd1);
        do_cycle(1'b0, '0);
        do_cycle(1'b0, '0);
        chk("x0_reads_zero", rf_mem[0], 64'd0);

        // Stall freezes arbitration
        for (int i = 0; i < NREQ; i++) s_rd[i] = 5'(i + 9);
        for (int c = 0; c < 3; c++) do_cycle(1'b1, '1);
        do_cycle(1'b0, '1);
        chk("stall_resume_grant", 64'(obs_ready), 64'(4'b0010));

        // Fairness: req3 steady, req0 toggling
        gcnt = 0;
        got3 = 1'b0;
        for (int c = 0; c < 8 && !got3; c++) begin
            do_cycle(1'b0, {1'b1, 2'b00, 1'(c)});
            if (obs_ready != '0) gcnt++;
            if (obs_ready[3]) got3 = 1'b1;
        end
        chk("fair_req3", 64'(got3 && gcnt <= NREQ), 64'd1);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                s_rd[i] = 5'($urandom_range(0, 31));
                s_wd[i] = {$urandom, $urandom};
            end
            do_cycle(($urandom % 5) == 0, NREQ'($urandom));
        end
        do_cycle(1'b0, '0);
        do_cycle(1'b0, '0);
        check_rf();

        // Reset mid-run with a write pending
        for (int i = 0; i < NREQ; i++) s_rd[i] = 5'(i + 20);
        do_cycle(1'b0, 4'b0100);
        @(negedge clk);
        chk("pre_rst_wb_we", 64'(wb_we), 64'd1);
        reset_n   = 1'b0;
        req_valid = '0;
        #1;
        chk("mid_rst_wb_we", 64'(wb_we), 64'd0);
        chk("mid_rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("mid_rst_wb_wd", wb_wd, 64'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        do_cycle(1'b0, '1);
        chk("post_rst_grant0", 64'(obs_ready), 64'd1);
        do_cycle(1'b0, '0);
        do_cycle(1'b0, '0);
        check_rf();

`ifdef WB_BYPASS_EN
        // Bypass of the in-flight write
        for (int i = 0; i < NREQ; i++) begin
            s_rd[i] = 5'd5;
            s_wd[i] = 64'h1234;
        end
        do_cycle(1'b0, '1);
        #1;
        rs1 = 5'd5;
        rs2 = 5'd0;
        #1;
        chk("byp_rd1", byp_rd1, 64'h1234);
        chk("byp_rf_rd1_old", rf_rd1, m_rf[5]);
        chk("byp_rd2_x0", byp_rd2, rf_rd2);
        do_cycle(1'b0, '0);
        do_cycle(1'b0, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write-back requesters (2..8).
REQ-002 Parameter XLEN, default 64, data width.
REQ-003 Port clk  input  1  clock, all state on rising edge.
REQ-004 Port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Port stall  input  1  freezes arbitration; no grant while high.
REQ-006 Port req_valid  input  NREQ  per-requester write request.
REQ-007 Port req_rd  input  NREQ x 5  per-requester destination register index.
REQ-008 Port req_wd  input  NREQ x XLEN  per-requester write data.
REQ-009 Port req_ready  output  NREQ  one-hot grant; handshake when req_valid[i] && req_ready[i].
REQ-010 Port wb_we  output  1  register-file write enable.
REQ-011 Port wb_rd  output  5  register-file destination index.
REQ-012 Port wb_wd  output  XLEN  register-file write data.

Function
REQ-013 req_ready SHALL be combinational, at most one bit set, all zero when stall=1 or no req_valid set.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer ptr, wraps NREQ-1 -> 0; first valid requester wins.
REQ-015 On a handshake to requester i, ptr SHALL update to (i+1) mod NREQ at that edge; no handshake leaves ptr unchanged.
REQ-016 A handshake at edge N SHALL drive wb_we/wb_rd/wb_wd during cycle N+1 (one registered stage); register file updates at edge N+1.
REQ-017 Cycle with no handshake SHALL register wb_we=0; wb_rd/wb_wd hold previous values.
REQ-018 Handshake with req_rd=0 SHALL be accepted (ready asserted, ptr advances) but register wb_we=0 (x0 writes dropped).
REQ-019 Requester not granted SHALL keep req_valid/req_rd/req_wd stable until handshake; arbiter SHALL NOT depend on this for correctness.
REQ-020 stall asserted SHALL NOT cancel an already-registered output; wb_we from prior handshake still issues.
REQ-021 Any mix of valids, including all NREQ simultaneously, SHALL yield exactly one grant per non-stalled cycle; each valid requester granted within NREQ grant cycles (no starvation).

Reset
REQ-022 reset_n low SHALL immediately force wb_we=0, wb_rd=0, wb_wd=0, ptr=0.
REQ-023 Reset assertion mid-operation SHALL discard the pending registered write; no write issued after release until a new handshake.
REQ-024 First cycle after reset release SHALL give requester 0 highest priority.

Configuration
REQ-025 Macro WB_BYPASS_EN SHALL add ports rs1, rs2 (input 5), rf_rd1, rf_rd2 (input XLEN, from register file), byp_rd1, byp_rd2 (output XLEN).
REQ-026 With WB_BYPASS_EN: byp_rdK = wb_wd when wb_we=1 and wb_rd==rsK and rsK!=0, else rf_rdK; purely combinational.
REQ-027 Without WB_BYPASS_EN: those ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package regfile_pkg SHALL hold XLEN, REG_ADDR_W=5, NREG=32, and typedef wb_req_t {rd, wd}; shared with the register file.
REQ-029 Round-robin selection SHALL be sub-module rr_arbiter (inputs valid vector, ptr; output one-hot grant); ptr and output register live in regfile_wb_arbiter.

Verification
REQ-030 Reset: reset_n=0 mid-run with wb_we=1 -> wb_we=0, wb_rd=0, wb_wd=0 immediately; ptr=0 after release.
REQ-031 Contention: NREQ=4, all valid with rd=1..4 for 4 cycles -> grants 0,1,2,3; wb_rd 1,2,3,4 one cycle behind; register file x1..x4 hold respective wd.
REQ-032 x0 drop: req0 valid rd=0 wd=0xDEAD -> req_ready[0]=1, next-cycle wb_we=0, x0 reads 0.
REQ-033 Stall: all valid, stall=1 for 3 cycles -> req_ready=0, ptr unchanged; first cycle after stall grants ptr requester.
REQ-034 Fairness: req3 held valid, req0 toggles every cycle -> req3 granted within 4 grant cycles.
REQ-035 Bypass (WB_BYPASS_EN): handshake rd=5 wd=0x1234, next cycle rs1=5 -> byp_rd1=0x1234 while rf_rd1 still old; rs2=0 with wb_rd=0 -> byp_rd2=rf_rd2.
